// File: rtl/cs10_top_core.sv
// ---------------------------------------------------------------------------
// cs10_top_core
// Register/control core of the CS10 FPGA. Acts as a slave on the 16-bit
// multiplexed MIB host bus and turns each MIB transaction into a single
// access on an internal 24-bit-address / 32-bit-data command bus. The
// command-bus targets are the ID, SCRATCH, STATUS and CTRL registers. The
// block also latches sticky error flags from the downstream FPGAs, drives the
// four inter-FPGA link pattern buses and produces a heartbeat LED.
//
// Ports
//   i_sysclk         system clock, all logic is synchronous to it
//   i_srst           reset, asynchronous assert, active-high
//   i_mib_start      master start strobe (address phase 1)
//   i_mib_rd_wr_n    1 = read, 0 = write, valid with i_mib_start
//   mib_dabus        shared address/data bus, driven only in read data beats
//   o_mib_slave_ack  write-complete pulse / read-data-valid strobe
//   error_dect_50    per-link error flags, group 50 (asynchronous)
//   error_dect_125   per-link error flags, group 125 (asynchronous)
//   IL07/IL68/IL12/IL34  link pattern buses {link_id[2:0], counter[67:0]}
//   led_check        heartbeat, forced high while any sticky error is set
// ---------------------------------------------------------------------------
module cs10_top_core #(
    parameter int          P_CMD_ACK_TIMEOUT_CLKS = 16,
    parameter logic [3:0]  P_MIB_MSN              = 4'h0,
    parameter logic [31:0] P_ID                   = 32'hC5100A01,
    parameter int          P_LED_DIV_BITS         = 24
) (
    input  logic        i_sysclk,
    input  logic        i_srst,
    input  logic        i_mib_start,
    input  logic        i_mib_rd_wr_n,
    inout  wire  [15:0] mib_dabus,
    output logic        o_mib_slave_ack,
    input  logic [3:0]  error_dect_50,
    input  logic [3:0]  error_dect_125,
    output logic [70:0] IL07,
    output logic [70:0] IL68,
    output logic [70:0] IL12,
    output logic [70:0] IL34,
    output logic        led_check
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR2  = 3'd1;
    localparam logic [2:0] S_WDATA1 = 3'd2;
    localparam logic [2:0] S_WDATA2 = 3'd3;
    localparam logic [2:0] S_CMD    = 3'd4;
    localparam logic [2:0] S_RDATA1 = 3'd5;
    localparam logic [2:0] S_RDATA2 = 3'd6;

    localparam int          TW        = $clog2(P_CMD_ACK_TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(P_CMD_ACK_TIMEOUT_CLKS - 1);

    logic [2:0]    state_reg, state_next;
    logic          rd_wr_n_reg;
    logic [23:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [31:0]   rdata_reg;
    logic [TW-1:0] timer_reg;
    logic          wr_ack_reg;

    // Internal command bus
    logic          cmd_sel_reg;
    logic          cmd_ack_reg;
    logic [31:0]   cmd_rdata_reg;

    // Registers
    logic [31:0]   scratch_reg;
    logic          pattern_en_reg;
    logic [7:0]    err_sync1_reg, err_sync2_reg;
    logic [7:0]    sticky_reg;      // {group 125, group 50}
    logic [67:0]   pat_cnt_reg;
    logic [P_LED_DIV_BITS-1:0] hb_cnt_reg;
    logic          led_reg;

    logic          hit;
    logic          decode_ok;
    logic          reg_wr;
    logic          clear_sticky;
    logic [31:0]   rd_mux;
    logic          drive_en;
    logic [15:0]   drive_data;

    // Only the top address nibble selects this slave; a miss still walks
    // through the bus phases so the master sees a normal (unacked) cycle.
    assign hit       = (addr_reg[23:20] == P_MIB_MSN);
    assign decode_ok = (addr_reg[19:4] == 16'h0);

    // ---------------- MIB FSM ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (i_mib_start) state_next = S_ADDR2;
            S_ADDR2:  state_next = rd_wr_n_reg ? S_CMD : S_WDATA1;
            S_WDATA1: state_next = S_WDATA2;
            S_WDATA2: state_next = S_CMD;
            S_CMD: begin
                if (!hit)
                    state_next = S_IDLE;
                else if (cmd_ack_reg)
                    state_next = rd_wr_n_reg ? S_RDATA1 : S_IDLE;
                else if (timer_reg == TIMER_LAST)
                    state_next = S_IDLE;
            end
            S_RDATA1: state_next = S_RDATA2;
            S_RDATA2: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sysclk or posedge i_srst) begin
        if (i_srst) begin
            state_reg   <= S_IDLE;
            rd_wr_n_reg <= 1'b0;
            addr_reg    <= 24'h0;
            wdata_reg   <= 32'h0;
            rdata_reg   <= 32'h0;
            timer_reg   <= '0;
            wr_ack_reg  <= 1'b0;
            cmd_sel_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: if (i_mib_start) begin
                    rd_wr_n_reg     <= i_mib_rd_wr_n;
                    addr_reg[23:16] <= mib_dabus[7:0];
                end
                S_ADDR2:  addr_reg[15:0]   <= mib_dabus;
                S_WDATA1: wdata_reg[31:16] <= mib_dabus;
                S_WDATA2: wdata_reg[15:0]  <= mib_dabus;
                S_CMD:    if (cmd_ack_reg) rdata_reg <= cmd_rdata_reg;
                default:  ;
            endcase
            // One-clock select on entry to CMD, suppressed on a slave miss
            cmd_sel_reg <= (state_next == S_CMD) && (state_reg != S_CMD) && hit;
            timer_reg   <= (state_reg == S_CMD) ? timer_reg + 1'b1 : '0;
            wr_ack_reg  <= (state_reg == S_CMD) && hit && cmd_ack_reg && !rd_wr_n_reg;
        end
    end

    assign drive_en        = (state_reg == S_RDATA1) || (state_reg == S_RDATA2);
    assign drive_data      = (state_reg == S_RDATA1) ? rdata_reg[31:16] : rdata_reg[15:0];
    assign mib_dabus       = drive_en ? drive_data : 16'hzzzz;
    assign o_mib_slave_ack = drive_en || wr_ack_reg;

    // ---------------- Register file ----------------
    always_comb begin
        rd_mux = 32'h0;
        case (addr_reg[3:2])
            2'd0: rd_mux = P_ID;
            2'd1: rd_mux = scratch_reg;
            2'd2: rd_mux = {24'h0, sticky_reg};
            2'd3: rd_mux = {31'h0, pattern_en_reg};
            default: rd_mux = 32'h0;
        endcase
    end

    assign reg_wr       = cmd_sel_reg && decode_ok && !rd_wr_n_reg;
    assign clear_sticky = reg_wr && (addr_reg[3:2] == 2'd3) && wdata_reg[1];

    always_ff @(posedge i_sysclk or posedge i_srst) begin
        if (i_srst) begin
            cmd_ack_reg    <= 1'b0;
            cmd_rdata_reg  <= 32'h0;
            scratch_reg    <= 32'h0;
            pattern_en_reg <= 1'b0;
        end else begin
            // Out-of-range addresses never ack and run into the CMD timeout
            cmd_ack_reg <= cmd_sel_reg && decode_ok;
            if (cmd_sel_reg && decode_ok)
                cmd_rdata_reg <= rd_mux;
            if (reg_wr && addr_reg[3:2] == 2'd1)
                scratch_reg <= wdata_reg;
            if (reg_wr && addr_reg[3:2] == 2'd3)
                pattern_en_reg <= wdata_reg[0];
        end
    end

    // ---------------- Sticky errors ----------------
    always_ff @(posedge i_sysclk or posedge i_srst) begin
        if (i_srst) begin
            err_sync1_reg <= 8'h0;
            err_sync2_reg <= 8'h0;
            sticky_reg    <= 8'h0;
        end else begin
            err_sync1_reg <= {error_dect_125, error_dect_50};
            err_sync2_reg <= err_sync1_reg;
            // A flag arriving in the same clock as a clear survives it
            if (clear_sticky)
                sticky_reg <= err_sync2_reg;
            else
                sticky_reg <= sticky_reg | err_sync2_reg;
        end
    end

    // ---------------- Link patterns ----------------
    always_ff @(posedge i_sysclk or posedge i_srst) begin
        if (i_srst)
            pat_cnt_reg <= 68'h0;
        else if (pattern_en_reg)
            pat_cnt_reg <= pat_cnt_reg + 68'h1;
    end

    logic [70:0] il_reg [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_link
            always_ff @(posedge i_sysclk or posedge i_srst) begin
                if (i_srst)
                    il_reg[gi] <= {3'(gi), 68'h0};
                else
                    il_reg[gi] <= {3'(gi), pat_cnt_reg};
            end
        end
    endgenerate

    assign IL07 = il_reg[0];
    assign IL68 = il_reg[1];
    assign IL12 = il_reg[2];
    assign IL34 = il_reg[3];

    // ---------------- Heartbeat ----------------
    always_ff @(posedge i_sysclk or posedge i_srst) begin
        if (i_srst) begin
            hb_cnt_reg <= '0;
            led_reg    <= 1'b0;
        end else begin
            hb_cnt_reg <= hb_cnt_reg + 1'b1;
            led_reg    <= hb_cnt_reg[P_LED_DIV_BITS-1] | (|sticky_reg);
        end
    end

    assign led_check = led_reg;

endmodule

// File: tb/tb_cs10_top_core.sv
// ---------------------------------------------------------------------------
// tb_cs10_top_core
// Directed bench for cs10_top_core. Stimulus tasks issue MIB transactions and
// push the expected ack/read beats into a queue; a monitor on the falling edge
// pops and compares whenever o_mib_slave_ack is seen. Transactions expected to
// be ignored open a "quiet" window in which any ack or bus drive is an error.
// While the DUT should not drive, the bench holds the bus at 16'h0000.
// ---------------------------------------------------------------------------
module tb_cs10_top_core;

    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic        i_mib_start;
    logic        i_mib_rd_wr_n;
    wire  [15:0] mib_dabus;
    logic        o_mib_slave_ack;
    logic [3:0]  error_dect_50;
    logic [3:0]  error_dect_125;
    logic [70:0] IL07, IL68, IL12, IL34;
    logic        led_check;

    logic        tb_oe;
    logic [15:0] tb_bus;
    logic        quiet;

    assign mib_dabus = tb_oe ? tb_bus : 16'hzzzz;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic        is_rd;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];

    cs10_top_core dut (
        .i_sysclk        (clk),
        .i_srst          (rst),
        .i_mib_start     (i_mib_start),
        .i_mib_rd_wr_n   (i_mib_rd_wr_n),
        .mib_dabus       (mib_dabus),
        .o_mib_slave_ack (o_mib_slave_ack),
        .error_dect_50   (error_dect_50),
        .error_dect_125  (error_dect_125),
        .IL07            (IL07),
        .IL68            (IL68),
        .IL12            (IL12),
        .IL34            (IL34),
        .led_check       (led_check)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    // ---------------- Monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (o_mib_slave_ack) begin
                n_vec++;
                if (quiet || exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_ack: got ack=1 bus=%h, required no ack", mib_dabus);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.is_rd) begin
                        if (mib_dabus !== e.data) begin
                            n_err++;
                            $display("FAIL rd_beat: got %h, required %h", mib_dabus, e.data);
                        end
                    end else begin
                        if (mib_dabus !== 16'h0000) begin
                            n_err++;
                            $display("FAIL wr_ack_bus: got %h, required %h (bus not driven)", mib_dabus, 16'h0000);
                        end
                    end
                end
            end else if (quiet) begin
                n_vec++;
                if (mib_dabus !== 16'h0000) begin
                    n_err++;
                    $display("FAIL bus_released: got %h, required %h (bus not driven)", mib_dabus, 16'h0000);
                end
            end
        end
    end

    // ---------------- Helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 40) begin
            @(posedge clk);
            i++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_window();
        quiet = 1'b1;
        repeat (TO + 8) @(posedge clk);
        #1;
        quiet = 1'b0;
    endtask

    task automatic mib_write(input logic [23:0] addr, input logic [31:0] data, input bit expect_ack);
        $display("WR addr=%h data=%h expect_ack=%0d", addr, data, expect_ack);
        @(posedge clk); #1;
        i_mib_start   = 1'b1;
        i_mib_rd_wr_n = 1'b0;
        tb_oe         = 1'b1;
        tb_bus        = {8'h00, addr[23:16]};
        @(posedge clk); #1;
        i_mib_start = 1'b0;
        tb_bus      = addr[15:0];
        @(posedge clk); #1;
        tb_bus = data[31:16];
        @(posedge clk); #1;
        tb_bus = data[15:0];
        @(posedge clk); #1;
        tb_bus = 16'h0000;
        if (expect_ack) begin
            exp_q.push_back('{is_rd: 1'b0, data: 16'h0000});
            drain("wr");
        end else begin
            quiet_window();
        end
    endtask

    task automatic mib_read(input logic [23:0] addr, input logic [31:0] data, input bit expect_ack);
        $display("RD addr=%h expect=%h expect_ack=%0d", addr, data, expect_ack);
        @(posedge clk); #1;
        i_mib_start   = 1'b1;
        i_mib_rd_wr_n = 1'b1;
        tb_oe         = 1'b1;
        tb_bus        = {8'h00, addr[23:16]};
        @(posedge clk); #1;
        i_mib_start = 1'b0;
        tb_bus      = addr[15:0];
        @(posedge clk); #1;
        if (expect_ack) begin
            tb_oe = 1'b0;
            exp_q.push_back('{is_rd: 1'b1, data: data[31:16]});
            exp_q.push_back('{is_rd: 1'b1, data: data[15:0]});
            drain("rd");
            tb_oe  = 1'b1;
            tb_bus = 16'h0000;
        end else begin
            tb_bus = 16'h0000;
            quiet_window();
        end
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        logic [70:0] a;
        logic [70:0] b;
        logic [67:0] d;

        rst            = 1'b1;
        i_mib_start    = 1'b0;
        i_mib_rd_wr_n  = 1'b0;
        error_dect_50  = 4'h0;
        error_dect_125 = 4'h0;
        tb_oe          = 1'b1;
        tb_bus         = 16'h0000;
        quiet          = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ack", 128'(o_mib_slave_ack), 128'(1'b0));
        chk("reset_led", 128'(led_check), 128'(1'b0));
        chk("reset_il07", 128'(IL07), 128'({3'd0, 68'h0}));
        chk("reset_il68", 128'(IL68), 128'({3'd1, 68'h0}));
        chk("reset_il12", 128'(IL12), 128'({3'd2, 68'h0}));
        chk("reset_il34", 128'(IL34), 128'({3'd3, 68'h0}));
        @(posedge clk); #1;
        rst = 1'b0;

        // Register reads/writes
        mib_read (24'h000008, 32'h00000000, 1'b1);
        mib_read (24'h000000, 32'hC5100A01, 1'b1);
        mib_write(24'h000004, 32'h01010202, 1'b1);
        mib_read (24'h000004, 32'h01010202, 1'b1);

        // Unmapped address times out, next access still works
        mib_read (24'h000010, 32'h00000000, 1'b0);
        mib_read (24'h000004, 32'h01010202, 1'b1);
        mib_write(24'h000014, 32'h12345678, 1'b0);

        // Other slave's address space
        mib_write(24'h100004, 32'hDEADBEEF, 1'b0);
        mib_read (24'h100004, 32'h00000000, 1'b0);
        mib_read (24'h000004, 32'h01010202, 1'b1);

        // Sticky error, group 50 bit 2
        @(posedge clk); #1;
        error_dect_50 = 4'b0100;
        @(posedge clk); #1;
        error_dect_50 = 4'b0000;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("led_sticky", 128'(led_check), 128'(1'b1));
        mib_read (24'h000008, 32'h00000004, 1'b1);
        mib_write(24'h00000C, 32'h00000002, 1'b1);
        mib_read (24'h000008, 32'h00000000, 1'b1);
        @(negedge clk);
        chk("led_cleared", 128'(led_check), 128'(1'b0));

        // Sticky error, group 125 bit 1
        @(posedge clk); #1;
        error_dect_125 = 4'b0010;
        @(posedge clk); #1;
        error_dect_125 = 4'b0000;
        repeat (5) @(posedge clk);
        mib_read (24'h000008, 32'h00000020, 1'b1);
        mib_write(24'h00000C, 32'h00000002, 1'b1);
        mib_read (24'h000008, 32'h00000000, 1'b1);

        // Pattern generator
        mib_write(24'h00000C, 32'h00000001, 1'b1);
        mib_read (24'h00000C, 32'h00000001, 1'b1);
        @(negedge clk);
        a = IL12;
        @(negedge clk);
        b = IL12;
        d = b[67:0] - a[67:0];
        chk("il12_id", 128'(b[70:68]), 128'(3'd2));
        chk("il12_inc", 128'(d), 128'(68'd1));
        chk("il34_id", 128'(IL34[70:68]), 128'(3'd3));
        mib_write(24'h00000C, 32'h00000000, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = IL12;
        repeat (3) @(negedge clk);
        b = IL12;
        d = b[67:0] - a[67:0];
        chk("il12_hold", 128'(d), 128'(68'd0));
        chk("il12_ran", 128'(a[67:0] != 68'd0), 128'(1'b1));
        mib_read (24'h00000C, 32'h00000000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
